// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int uart_bit_time(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte valid/ready handshake into the UART transmitter.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic                      data_valid_i;
    logic [UART_DATA_BITS-1:0] data_i;
    logic                      data_ready_o;

    modport master (
        output data_valid_i,
        output data_i,
        input  data_ready_o
    );

    modport slave (
        input  data_valid_i,
        input  data_i,
        output data_ready_o
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering bytes ahead of the serialiser.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [UART_DATA_BITS-1:0] wdata_i,
    output logic [UART_DATA_BITS-1:0] rdata_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [UART_DATA_BITS-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered 8N1 serialiser; define UART_TX_PARITY_EN
// for 8E1 (even parity bit between d7 and stop).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_MHZ    = 100_000_000,
    parameter int UART_SPEED_BAUD = 9600,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst,
    uart_transmitter_if.slave in_if,
    output logic         TX_o,
    output logic         busy_o
);

    localparam int BIT_TIME = uart_bit_time(CLK_FREQ_MHZ, UART_SPEED_BAUD);
    localparam int CW       = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TIME - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           full, empty, pop, wrap;
    logic [UART_DATA_BITS-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_if.data_valid_i),
        .pop_i   (pop),
        .wdata_i (in_if.data_i),
        .rdata_o (fifo_data),
        .full_o  (full),
        .empty_o (empty)
    );

    assign in_if.data_ready_o = !full && !rst;
    assign wrap = (cnt_q == LAST_TICK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (wrap) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_data;
`endif
        end
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TX_o   = tx_q;
    assign busy_o = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: line-decoding monitor against a byte scoreboard.
module tb_uart_transmitter;

    localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic TX_o;
    logic busy_o;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    uart_transmitter_if bus();

    uart_transmitter #(
        .CLK_FREQ_MHZ    (160),
        .UART_SPEED_BAUD (10),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_if  (bus),
        .TX_o   (TX_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a byte and hold it until accepted.
    task automatic push(input logic [7:0] b);
        logic acc;
        int   to;
        acc = 1'b0;
        to  = 0;
        bus.data_valid_i = 1'b1;
        bus.data_i       = b;
        while (!acc && to < 2000) begin
            @(negedge clk);
            acc = bus.data_ready_o;
            @(posedge clk);
            #1;
            to++;
        end
        bus.data_valid_i = 1'b0;
        if (acc) exp_q.push_back(b);
        else check("push_timeout", 32'd1, 32'd0);
    endtask

    // Offer a byte for exactly one cycle.
    task automatic try_push(input logic [7:0] b, output logic acc);
        bus.data_valid_i = 1'b1;
        bus.data_i       = b;
        @(negedge clk);
        acc = bus.data_ready_o;
        @(posedge clk);
        #1;
        bus.data_valid_i = 1'b0;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (busy_o && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("busy_clear", busy_o, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("all_frames_seen", exp_q.size(), 0);
    endtask

    task automatic check_starts(input int n);
        check("frame_count", starts_q.size(), n);
        for (int i = 1; i < starts_q.size(); i++) begin
            check("frame_gap", starts_q[i] - starts_q[i-1], NB * BT);
        end
    endtask

    // Monitor: decode each frame off the line and score it.
    initial begin : monitor
        logic [NB-1:0] bv;
        logic [7:0]    e;
        bit            glitch, aborted;
        int            s;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && TX_o === 1'b0) begin
                s = cyc;
                glitch = 0;
                aborted = 0;
                bv = '0;
                for (int k = 0; k < NB; k++) begin
                    for (int c = 0; c < BT; c++) begin
                        if (k != 0 || c != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (rst) aborted = 1;
                        if (c == 0) bv[k] = TX_o;
                        else if (TX_o !== bv[k]) glitch = 1;
                    end
                end
                if (!aborted) begin
                    starts_q.push_back(s);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, bv[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", bv[8:1], e);
                        check("frame_shape", {glitch, bv[0], bv[NB-1]}, 3'b001);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", bv[9], $countones(e) % 2);
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic acc;
        int   n;
        int   gap;
        rst = 1'b1;
        bus.data_valid_i = 1'b0;
        bus.data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", bus.data_ready_o, 1'b0);
        check("tx_reset", TX_o, 1'b1);
        check("busy_reset", busy_o, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.data_ready_o, 1'b1);

        // Single byte: latency and frame length.
        starts_q.delete();
        push(8'hA5);
        check("tx_high_n1", TX_o, 1'b1);
        @(posedge clk);
        #1;
        n = 1;
        check("tx_low_n2", TX_o, 1'b0);
        while (busy_o && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_cycles", n, 1 + NB * BT);
        drain();

        // Back-to-back frames.
        starts_q.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        push(8'h81);
        drain();
        check_starts(4);

        // Overflow: fifth push fills, sixth refused, seventh held.
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        push(8'h50);
        @(negedge clk);
        check("ready_full", bus.data_ready_o, 1'b0);
        @(posedge clk);
        #1;
        try_push(8'hDE, acc);
        check("refused_when_full", acc, 1'b0);
        push(8'h5A);
        drain();

        // Reset during d3 of 0x3C with two bytes queued.
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        repeat (66) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("tx_after_rst", TX_o, 1'b1);
        check("busy_after_rst", busy_o, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", bus.data_ready_o, 1'b1);
        n = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (TX_o !== 1'b1) n++;
        end
        check("silent_after_rst", n, 0);
        check("idle_after_rst", busy_o, 1'b0);

        // Loopback bytes.
        push(8'h12);
        push(8'hEF);
        drain();

`ifdef UART_TX_PARITY_EN
        starts_q.delete();
        push(8'h07);
        push(8'h03);
        drain();
        check_starts(2);
`endif

        // Random traffic with random gaps, including idle stretches.
        for (int i = 0; i < 20; i++) begin
            push(8'($urandom));
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 400)
                                              : $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmit stage that feeds the receive path: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises each as an 8N1 frame (optionally 8E1) on `TX_o`. Sits between the byte-producing logic and the line into `UART_receiver`, at the same baud configuration, so frames loop back cleanly.

## Interface
- `CLK_FREQ_MHZ`, default 100_000_000: clock frequency in Hz (name kept for consistency with the receiver).
- `UART_SPEED_BAUD`, default 9600: line rate in baud.
- `FIFO_DEPTH`, default 4: input buffer entries; power of two, ≥2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset: one clock; reset is synchronous and active-high.
- `data_valid_i`  input  1  producer has a byte on `data_i`.
- `data_i`  input  8  byte to send.
- `data_ready_o`  output  1  FIFO can accept a byte this cycle.
- `TX_o`  output  1  serial line, idle high, registered.
- `busy_o`  output  1  frame in progress or FIFO non-empty.

## Operation
- `BIT_TIME = CLK_FREQ_MHZ / UART_SPEED_BAUD`, integer division; each bit is held exactly `BIT_TIME` cycles. Bit-time counter is `$clog2(BIT_TIME)` bits wide, counts 0..BIT_TIME-1 and wraps to 0.
- Push happens when `data_valid_i && data_ready_o`. `data_ready_o = !full`, which depends only on occupancy. When full, a push is refused even if a pop occurs in the same cycle.
- Frame: start bit 0, then data bits d0..d7 (LSB first), then the parity bit if enabled, then stop bit 1.
- FSM states:
  - IDLE: `TX_o`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `TX_o`=0 for BIT_TIME cycles, then go to DATA.
  - DATA: 4-bit bit counter runs 0..7; shift right at each bit-time wrap. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: one bit time, then go to STOP.
  - STOP: `TX_o`=1. On the last STOP cycle, if the FIFO is non-empty, pop and go to START (no idle gap). Otherwise go to IDLE.
- `TX_o` is driven from a flop computed from the next state and the next shift-register LSB.
- `busy_o = (state != IDLE) | !empty`.
- Reset mid-frame aborts the frame and flushes the FIFO. `TX_o` is 1 from the first cycle after the reset edge.

## Timing
- Reset values: `TX_o`=1, `busy_o`=0. `data_ready_o`=0 while `rst` is high and 1 in the first cycle after reset.
- Latency with the FIFO empty and the FSM in IDLE: push accepted in cycle N, pop at the end of N+1, `TX_o` falls at the start of N+2.
- Frame length: 10·BIT_TIME cycles, or 11·BIT_TIME with parity.
- Back-to-back bytes produce contiguous frames: the stop bit is followed immediately by the next start bit.
- Simultaneous push and pop while not full: both take effect and occupancy is unchanged.
- The FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Occupancy is a separate counter of `$clog2(FIFO_DEPTH)+1` bits.

## Configuration
- `UART_TX_PARITY_EN` defined: adds the PARITY state and sends an even parity bit (`^data`) between d7 and stop, giving 11·BIT_TIME per frame.
- `UART_TX_PARITY_EN` undefined: no PARITY state or logic is built, giving 8N1 and 10·BIT_TIME per frame.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS = 8`.
  - Function `uart_bit_time(freq, baud)`.
- One sub-module: `uart_tx_fifo`, a synchronous FIFO parameterised by `FIFO_DEPTH` with full/empty flags and the same `clk`/`rst`. The FSM, bit-time counter and shift register stay in the top level.

## Test plan
Simulation parameters: CLK_FREQ_MHZ=160, UART_SPEED_BAUD=10, giving BIT_TIME=16.
- Single byte 0xA5 pushed after reset → `TX_o` low at N+2; line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; `busy_o` drops after 160 cycles.
- Four pushes 0x00, 0xFF, 0x55, 0x81 on consecutive cycles → all accepted; four contiguous frames with no idle bits between them; order preserved.
- Six pushes on consecutive cycles with FIFO_DEPTH=4 → `data_ready_o` falls once the FIFO is full; the refused byte is not sent; the byte held until ready reasserts is sent next.
- `rst` asserted during bit d3 of 0x3C with two bytes queued → `TX_o`=1, `busy_o`=0 and the FIFO empty after the edge; nothing is transmitted afterwards.
- Loopback of `TX_o` into `UART_receiver` with the same parameters, bytes 0x12 and 0xEF → the receiver returns matching bytes.
- With `UART_TX_PARITY_EN`: 0x07 → parity bit 1; 0x03 → parity bit 0; frame length 176 cycles.
